// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the hazard/flush controller: default widths and
// the exception-redirect FSM state type.
package cpu_defs_pkg;

  localparam int unsigned HZ_REG_AW  = 5;
  localparam int unsigned HZ_ISSUE_W = 2;

  typedef enum logic [0:0] {
    HZ_NORMAL   = 1'b0,
    HZ_EXC_WAIT = 1'b1
  } hz_state_e;

endpackage

// File: rtl/hz_dep_match.sv
// One decode slot's load-use check: does rs or rt (excluding $0) match the
// destination of any load currently in E or M?
module hz_dep_match
  import cpu_defs_pkg::*;
#(
  parameter int unsigned ISSUE_W = HZ_ISSUE_W,
  parameter int unsigned REG_AW  = HZ_REG_AW
) (
  input  logic                      valid_i,
  input  logic [REG_AW-1:0]         rs_i,
  input  logic [REG_AW-1:0]         rt_i,
  input  logic [ISSUE_W-1:0]        e_load_i,
  input  logic [ISSUE_W*REG_AW-1:0] e_waddr_i,
  input  logic [ISSUE_W-1:0]        m_load_i,
  input  logic [ISSUE_W*REG_AW-1:0] m_waddr_i,
  output logic                      hit_o
);

  logic rs_hit;
  logic rt_hit;

  // Compare both sources against every E/M load destination; mask $0.
  always_comb begin
    rs_hit = 1'b0;
    rt_hit = 1'b0;
    for (int unsigned k = 0; k < ISSUE_W; k++) begin
      if (e_load_i[k] && (e_waddr_i[k*REG_AW +: REG_AW] == rs_i)) rs_hit = 1'b1;
      if (m_load_i[k] && (m_waddr_i[k*REG_AW +: REG_AW] == rs_i)) rs_hit = 1'b1;
      if (e_load_i[k] && (e_waddr_i[k*REG_AW +: REG_AW] == rt_i)) rt_hit = 1'b1;
      if (m_load_i[k] && (m_waddr_i[k*REG_AW +: REG_AW] == rt_i)) rt_hit = 1'b1;
    end
    hit_o = valid_i & ((rs_hit & (|rs_i)) | (rt_hit & (|rt_i)));
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Multi-issue pipeline hazard/flush controller: load-use and global stalls,
// pending-branch flush held across stalls, exception redirect FSM that waits
// out an I-cache miss, and a sticky fetch-stall watchdog.
module pipe_hazard_ctrl
  import cpu_defs_pkg::*;
#(
  parameter int unsigned ISSUE_W = HZ_ISSUE_W,
  parameter int unsigned REG_AW  = HZ_REG_AW,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [ISSUE_W-1:0]        D_valid,
  input  logic [ISSUE_W*REG_AW-1:0] D_rs,
  input  logic [ISSUE_W*REG_AW-1:0] D_rt,
  input  logic [ISSUE_W-1:0]        E_memtoReg,
  input  logic [ISSUE_W*REG_AW-1:0] E_waddr,
  input  logic [ISSUE_W-1:0]        M_memtoReg,
  input  logic [ISSUE_W*REG_AW-1:0] M_waddr,
  input  logic                      E_branch_taken,
  input  logic                      E_div_stall,
  input  logic                      i_stall,
  input  logic                      d_stall,
  input  logic                      M_except,
  output logic                      F_ena,
  output logic                      D_ena,
  output logic                      E_ena,
  output logic                      M_ena,
  output logic                      W_ena,
  output logic                      F_flush,
  output logic                      D_flush,
  output logic                      E_flush,
  output logic                      M_flush,
  output logic                      W_flush,
  output logic                      stall_timeout
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_SET = CW'(TIMEOUT - 1);

  hz_state_e     state_q, state_d;
  logic          br_pend_q, br_pend_d;
  logic [CW-1:0] stall_cnt_q, stall_cnt_d;
  logic          timeout_q, timeout_d;

  logic [ISSUE_W-1:0] slot_hit;
  logic lwstall, gstall, brq, exc_wait, f_run;

  for (genvar s = 0; s < ISSUE_W; s++) begin : g_slot
    hz_dep_match #(
      .ISSUE_W (ISSUE_W),
      .REG_AW  (REG_AW)
    ) u_match (
      .valid_i   (D_valid[s]),
      .rs_i      (D_rs[s*REG_AW +: REG_AW]),
      .rt_i      (D_rt[s*REG_AW +: REG_AW]),
      .e_load_i  (E_memtoReg),
      .e_waddr_i (E_waddr),
      .m_load_i  (M_memtoReg),
      .m_waddr_i (M_waddr),
      .hit_o     (slot_hit[s])
    );
  end

  // Hazard terms shared by enables, flushes and next-state logic.
  always_comb begin
    lwstall  = |slot_hit;
    gstall   = E_div_stall | d_stall;
    brq      = (E_branch_taken | br_pend_q) & ~gstall;
    exc_wait = (state_q == HZ_EXC_WAIT);
    f_run    = ~(lwstall | gstall | i_stall);
  end

  // Stage enables and flushes; reset forces everything frozen and flushed.
  always_comb begin
    F_ena   = f_run;
    D_ena   = ~(lwstall | gstall);
    E_ena   = ~gstall;
    M_ena   = ~gstall;
    W_ena   = ~gstall;
    F_flush = exc_wait;
    D_flush = M_except | brq | exc_wait;
    E_flush = M_except | brq;
    M_flush = M_except;
    W_flush = M_except;
    if (!resetn) begin
      F_ena   = 1'b0;
      D_ena   = 1'b0;
      E_ena   = 1'b0;
      M_ena   = 1'b0;
      W_ena   = 1'b0;
      F_flush = 1'b1;
      D_flush = 1'b1;
      E_flush = 1'b1;
      M_flush = 1'b1;
      W_flush = 1'b1;
    end
    stall_timeout = timeout_q;
  end

  // Next state: exception redirect FSM, pending branch, watchdog.
  always_comb begin
    state_d = state_q;
    case (state_q)
      HZ_NORMAL:   if (M_except && i_stall) state_d = HZ_EXC_WAIT;
      HZ_EXC_WAIT: if (!M_except && !i_stall) state_d = HZ_NORMAL;
      default:     state_d = HZ_NORMAL;
    endcase

    // An exception wins over both consuming and arming a branch flush.
    br_pend_d = br_pend_q;
    if (M_except)                        br_pend_d = 1'b0;
    else if (brq)                        br_pend_d = 1'b0;
    else if (E_branch_taken && gstall)   br_pend_d = 1'b1;

    if (f_run)                           stall_cnt_d = '0;
    else if (stall_cnt_q == CNT_MAX)     stall_cnt_d = stall_cnt_q;
    else                                 stall_cnt_d = stall_cnt_q + 1'b1;

    timeout_d = timeout_q | (~f_run & (stall_cnt_q == CNT_SET));
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= HZ_NORMAL;
      br_pend_q   <= 1'b0;
      stall_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      br_pend_q   <= br_pend_d;
      stall_cnt_q <= stall_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Parametrised pipeline hazard/flush controller for the multi-issue MIPS core; successor to the single-slot hazard unit.
- Generalises load-use detection to ISSUE_W decode slots and ISSUE_W load results per stage, and excludes $0.
- Adds I/D-cache stall handling, a registered pending-branch flush across stalls, and an exception-redirect FSM.
- Adds a stall watchdog. Sits beside the F/D/E/M/W pipeline registers and drives their enable/flush inputs.

Parameters:
ISSUE_W, 2, number of decode/issue slots (slot 0 = master)
REG_AW, 5, register address width
TIMEOUT, 1024, consecutive F-stall cycles before stall_timeout sets (>=2)

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
D_valid  in  ISSUE_W  decode slot valid
D_rs  in  ISSUE_W*REG_AW  source rs per slot, slot i at bits [i*REG_AW +: REG_AW]
D_rt  in  ISSUE_W*REG_AW  source rt per slot
E_memtoReg  in  ISSUE_W  E slot is a load
E_waddr  in  ISSUE_W*REG_AW  E slot dest reg
M_memtoReg  in  ISSUE_W  M slot is a load
M_waddr  in  ISSUE_W*REG_AW  M slot dest reg
E_branch_taken  in  1  one-cycle pulse, branch resolved taken in E
E_div_stall  in  1  divider busy
i_stall  in  1  I-cache miss outstanding
d_stall  in  1  D-cache miss outstanding
M_except  in  1  exception committed in M
F_ena, D_ena, E_ena, M_ena, W_ena  out  1 each  stage enables
F_flush, D_flush, E_flush, M_flush, W_flush  out  1 each  stage flushes
stall_timeout  out  1  sticky watchdog flag

Behaviour:
- Reset, resetn=0 sampled at posedge:
  - State: FSM=NORMAL, br_pend=0, stall_cnt=0, stall_timeout=0.
  - While resetn=0 (combinational): all *_ena=0, all *_flush=1.
- Hazard terms:
  - gstall = E_div_stall | d_stall.
  - lwstall = OR over valid D slots s and load slots k, with addr = D_rs[s] or D_rt[s]: (E_memtoReg[k] & E_waddr[k]==addr & addr!=0) | (M_memtoReg[k] & M_waddr[k]==addr & addr!=0).
- Enables:
  - F_ena = ~(lwstall | gstall | i_stall).
  - D_ena = ~(lwstall | gstall).
  - E_ena = M_ena = W_ena = ~gstall.
- Branch:
  - Effective flush condition: brq = (E_branch_taken | br_pend) & ~gstall.
  - br_pend sets when E_branch_taken & gstall; clears when brq=1 or on exception.
  - brq drives D_flush=1 and E_flush=1 that cycle.
- Exception FSM, states NORMAL and EXC_WAIT:
  - NORMAL & M_except: D/E/M/W_flush=1 this cycle regardless of stalls; br_pend cleared. Next state is EXC_WAIT if i_stall=1, else NORMAL.
  - EXC_WAIT: F_flush=1 and D_flush=1 each cycle, to discard the stale in-flight fetch. Return to NORMAL on the cycle i_stall=0; flushes are still asserted on that cycle.
  - M_except in EXC_WAIT re-applies the D/E/M/W flushes; stays in EXC_WAIT.
  - Exception has priority over brq. F_flush=0 outside EXC_WAIT.
- Watchdog:
  - stall_cnt increments while F_ena=0 (saturates at TIMEOUT) and resets to 0 when F_ena=1.
  - stall_timeout sets when stall_cnt reaches TIMEOUT-1 and F_ena=0; sticky until reset.
- Latency:
  - Enables and flushes are combinational from inputs plus registered state.
  - State updates on posedge only.

Decomposition:
- Shared package cpu_defs_pkg: REG_AW, ISSUE_W default, FSM state enum (HZ_NORMAL, HZ_EXC_WAIT).
- One sub-module, hz_dep_match: the combinational one-slot source vs. ISSUE_W-dest match with the $0 mask, instantiated per decode slot.

Test Plan:
- Load-use: slot1 D_rt=5, E_memtoReg[0]=1, E_waddr[0]=5 -> F_ena=D_ena=0, E_ena=1. Repeat with E_waddr[0]=0 and D_rt=0 -> no stall.
- Branch across stall: E_branch_taken pulse while d_stall=1 for 3 cycles -> no flush during the stall; D_flush=E_flush=1 on exactly the first cycle d_stall=0, then br_pend=0.
- Exception plus I-miss: M_except=1 with i_stall=1 for 4 cycles -> cycle 0: D/E/M/W_flush=1. Then F_flush=D_flush=1 through the cycle i_stall drops, then NORMAL.
- Exception vs. branch: M_except and E_branch_taken in the same cycle -> M_flush=W_flush=1, br_pend stays 0, and no extra flush follows.
- Watchdog: TIMEOUT=8, hold E_div_stall=1 for 8 cycles -> stall_timeout rises at the 8th stalled cycle's edge, stays 1 after the stall ends, clears only on resetn=0.
- Reset mid-operation: resetn=0 while in EXC_WAIT with br_pend=1 -> all flushes=1 and all enables=0 during reset; after release FSM=NORMAL, br_pend=0, outputs follow the inputs.
